// File: rtl/id_issue_ctrl_pkg.sv
// Shared types and constants for the decode-stage
// dual-issue pairing / hazard controller.
package id_issue_ctrl_pkg;

  typedef enum logic {
    S_PAIR  = 1'b0,
    S_SPLIT = 1'b1
  } state_e;

  localparam logic [3:0] COND_AL = 4'hE;

  function automatic logic ld_hit(
    input logic       use_src,
    input logic [3:0] src,
    input logic       ld1e,
    input logic [3:0] rd1e,
    input logic       ld2e,
    input logic [3:0] rd2e
  );
    return use_src &
           ((ld1e & (src == rd1e)) |
            (ld2e & (src == rd2e)));
  endfunction

endpackage

// File: rtl/id_issue_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc,
// sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count with saturation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage dual-issue pairing and hazard control:
// split dependent pairs, stall load-use, squash on branch.
module id_issue_ctrl #(
  parameter int         CNT_WIDTH = 16,
  parameter logic [3:0] COND_AL   = 4'hE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_Valid1D,
  input  logic                 i_Valid2D,
  input  logic                 i_RegWrite1D,
  input  logic                 i_RegWrite2D,
  input  logic                 i_MemtoReg1D,
  input  logic                 i_MemtoReg2D,
  input  logic                 i_MemWrite1D,
  input  logic                 i_MemWrite2D,
  input  logic                 i_FlagWrite1D,
  input  logic [3:0]           i_Cond2,
  input  logic [3:0]           i_Rd1,
  input  logic [3:0]           i_Rd2,
  input  logic [3:0]           i_Rn1,
  input  logic [3:0]           i_Rm1,
  input  logic [3:0]           i_Rn2,
  input  logic [3:0]           i_Rm2,
  input  logic                 i_UseRn1,
  input  logic                 i_UseRm1,
  input  logic                 i_UseRn2,
  input  logic                 i_UseRm2,
  input  logic                 i_MemtoReg1E,
  input  logic                 i_MemtoReg2E,
  input  logic [3:0]           i_Rd1E,
  input  logic [3:0]           i_Rd2E,
  input  logic                 i_BranchTakenE,
  output logic                 o_StallF,
  output logic                 o_StallD,
  output logic                 o_FlushD,
  output logic                 o_Flush1E,
  output logic                 o_Flush2E,
  output logic                 o_SplitPending,
  output logic [CNT_WIDTH-1:0] o_SplitCnt,
  output logic [CNT_WIDTH-1:0] o_StallCnt
);

  import id_issue_ctrl_pkg::*;

  state_e state, state_n;

  logic raw, waw, flg, mem;
  logic intra, lu1, lu2, lu;
  logic do_br, do_lu, do_split, do_issue2;

  assign raw =
    i_RegWrite1D &
    ((i_UseRn2 & (i_Rn2 == i_Rd1)) |
     (i_UseRm2 & (i_Rm2 == i_Rd1)));
  assign waw =
    i_RegWrite1D & i_RegWrite2D &
    (i_Rd1 == i_Rd2);
  assign flg =
    i_FlagWrite1D & (i_Cond2 != COND_AL);
  assign mem =
    (i_MemtoReg1D | i_MemWrite1D) &
    (i_MemtoReg2D | i_MemWrite2D);
  assign intra =
    i_Valid1D & i_Valid2D &
    (raw | waw | flg | mem);

  assign lu1 = i_Valid1D & (
    ld_hit(i_UseRn1, i_Rn1, i_MemtoReg1E,
           i_Rd1E, i_MemtoReg2E, i_Rd2E) |
    ld_hit(i_UseRm1, i_Rm1, i_MemtoReg1E,
           i_Rd1E, i_MemtoReg2E, i_Rd2E));
  assign lu2 = i_Valid2D & (
    ld_hit(i_UseRn2, i_Rn2, i_MemtoReg1E,
           i_Rd1E, i_MemtoReg2E, i_Rd2E) |
    ld_hit(i_UseRm2, i_Rm2, i_MemtoReg1E,
           i_Rd1E, i_MemtoReg2E, i_Rd2E));
  assign lu = (state == S_SPLIT) ? lu2
                                 : (lu1 | lu2);

  // one-hot priority select: branch > lu > split
  assign do_br     = rst_n & i_BranchTakenE;
  assign do_lu     = rst_n & ~i_BranchTakenE & lu;
  assign do_split  = rst_n & ~i_BranchTakenE &
                     ~lu & (state == S_PAIR) &
                     intra;
  assign do_issue2 = rst_n & ~i_BranchTakenE &
                     ~lu & (state == S_SPLIT);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_PAIR;
    else
      state <= state_n;
  end

  // next state and pipeline controls
  always_comb begin
    state_n   = state;
    o_StallF  = 1'b0;
    o_StallD  = 1'b0;
    o_FlushD  = 1'b0;
    o_Flush1E = 1'b0;
    o_Flush2E = 1'b0;
    unique case (1'b1)
      do_br: begin
        o_FlushD  = 1'b1;
        o_Flush1E = 1'b1;
        o_Flush2E = 1'b1;
        state_n   = S_PAIR;
      end
      do_lu: begin
        o_StallF  = 1'b1;
        o_StallD  = 1'b1;
        o_Flush1E = 1'b1;
        o_Flush2E = 1'b1;
      end
      do_split: begin
        o_StallF  = 1'b1;
        o_StallD  = 1'b1;
        o_Flush2E = 1'b1;
        state_n   = S_SPLIT;
      end
      do_issue2: begin
        o_Flush1E = 1'b1;
        state_n   = S_PAIR;
      end
      default: ;
    endcase
  end

  assign o_SplitPending = rst_n & (state == S_SPLIT);

  sat_counter #(.W(CNT_WIDTH)) u_split_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (do_split),
    .cnt   (o_SplitCnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (do_lu),
    .cnt   (o_StallCnt)
  );

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed scoreboard bench for id_issue_ctrl
// with a 4-bit counter width.
module tb_id_issue_ctrl;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic v1, v2, rw1, rw2, mr1, mr2, mw1, mw2, fw1;
  logic [3:0] cond2, rd1, rd2, rn1, rm1, rn2, rm2;
  logic urn1, urm1, urn2, urm2;
  logic mr1e, mr2e, br;
  logic [3:0] rd1e, rd2e;
  logic sf, sd, fd, f1, f2, sp;
  logic [CW-1:0] scnt, stcnt;

  typedef struct {
    logic sf, sd, fd, f1, f2, sp;
    logic [CW-1:0] sc, stc;
  } exp_t;

  exp_t q[$];
  int cmps = 0;
  int fails = 0;
  logic [CW-1:0] sc_m = '0;
  logic [CW-1:0] stc_m = '0;

  always #5 clk = ~clk;

  id_issue_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_Valid1D      (v1),
    .i_Valid2D      (v2),
    .i_RegWrite1D   (rw1),
    .i_RegWrite2D   (rw2),
    .i_MemtoReg1D   (mr1),
    .i_MemtoReg2D   (mr2),
    .i_MemWrite1D   (mw1),
    .i_MemWrite2D   (mw2),
    .i_FlagWrite1D  (fw1),
    .i_Cond2        (cond2),
    .i_Rd1          (rd1),
    .i_Rd2          (rd2),
    .i_Rn1          (rn1),
    .i_Rm1          (rm1),
    .i_Rn2          (rn2),
    .i_Rm2          (rm2),
    .i_UseRn1       (urn1),
    .i_UseRm1       (urm1),
    .i_UseRn2       (urn2),
    .i_UseRm2       (urm2),
    .i_MemtoReg1E   (mr1e),
    .i_MemtoReg2E   (mr2e),
    .i_Rd1E         (rd1e),
    .i_Rd2E         (rd2e),
    .i_BranchTakenE (br),
    .o_StallF       (sf),
    .o_StallD       (sd),
    .o_FlushD       (fd),
    .o_Flush1E      (f1),
    .o_Flush2E      (f2),
    .o_SplitPending (sp),
    .o_SplitCnt     (scnt),
    .o_StallCnt     (stcnt)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    cmps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr();
    {v1, v2, rw1, rw2, mr1, mr2} = '0;
    {mw1, mw2, fw1, br} = '0;
    {urn1, urm1, urn2, urm2} = '0;
    {mr1e, mr2e} = '0;
    cond2 = 4'hE;
    {rd1, rd2, rn1, rm1, rn2, rm2} = '0;
    {rd1e, rd2e} = '0;
  endtask

  // slot 1 writes R2, slot 2 reads Rn=R2
  task automatic raw_pair();
    clr();
    v1 = 1; v2 = 1;
    rw1 = 1; rd1 = 4'd2;
    rn1 = 4'd8; rm1 = 4'd9;
    urn1 = 1; urm1 = 1;
    rw2 = 1; rd2 = 4'd6;
    rn2 = 4'd2; urn2 = 1;
  endtask

  task automatic run(input string tag,
                     input logic e_sf, e_sd, e_fd,
                     input logic e_f1, e_f2, e_sp);
    exp_t e, o;
    e = '{e_sf, e_sd, e_fd, e_f1, e_f2,
          e_sp, sc_m, stc_m};
    q.push_back(e);
    @(negedge clk);
    o = q.pop_front();
    chk({tag, ".StallF"},  8'(sf),  8'(o.sf));
    chk({tag, ".StallD"},  8'(sd),  8'(o.sd));
    chk({tag, ".FlushD"},  8'(fd),  8'(o.fd));
    chk({tag, ".Flush1E"}, 8'(f1),  8'(o.f1));
    chk({tag, ".Flush2E"}, 8'(f2),  8'(o.f2));
    chk({tag, ".SplitP"},  8'(sp),  8'(o.sp));
    chk({tag, ".SplitCnt"}, 8'(scnt), 8'(o.sc));
    chk({tag, ".StallCnt"}, 8'(stcnt), 8'(o.stc));
    if (rst_n && o.sf && o.f2 && !o.f1 &&
        sc_m != '1)
      sc_m = sc_m + 1'b1;
    if (rst_n && o.sf && o.f1 &&
        stc_m != '1)
      stc_m = stc_m + 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    run("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // reset while a split is pending
    raw_pair();
    run("presplit", 1, 1, 0, 0, 1, 0);
    rst_n = 1'b0;
    sc_m = '0;
    stc_m = '0;
    run("midrst", 0, 0, 0, 0, 0, 0);
    clr();
    rst_n = 1'b1;
    run("postrst", 0, 0, 0, 0, 0, 0);

    // independent pair
    clr();
    v1 = 1; v2 = 1;
    rw1 = 1; rd1 = 4'd1;
    rn1 = 4'd2; rm1 = 4'd3;
    urn1 = 1; urm1 = 1;
    rw2 = 1; rd2 = 4'd3;
    rn2 = 4'd4; rm2 = 4'd5;
    urn2 = 1; urm2 = 1;
    run("indep0", 0, 0, 0, 0, 0, 0);
    run("indep1", 0, 0, 0, 0, 0, 0);

    // RAW split
    raw_pair();
    run("raw0", 1, 1, 0, 0, 1, 0);
    run("raw1", 0, 0, 0, 1, 0, 1);
    clr();
    run("raw2", 0, 0, 0, 0, 0, 0);

    // invalid slot 2 never splits
    raw_pair();
    v2 = 0;
    run("inval", 0, 0, 0, 0, 0, 0);

    // WAW split
    clr();
    v1 = 1; v2 = 1;
    rw1 = 1; rw2 = 1;
    rd1 = 4'd5; rd2 = 4'd5;
    run("waw0", 1, 1, 0, 0, 1, 0);
    run("waw1", 0, 0, 0, 1, 0, 1);

    // flags: AL slot 2 pairs, conditional splits
    clr();
    v1 = 1; v2 = 1;
    fw1 = 1; rd1 = 4'd1; rd2 = 4'd2;
    run("flgal", 0, 0, 0, 0, 0, 0);
    cond2 = 4'h0;
    run("flg0", 1, 1, 0, 0, 1, 0);
    run("flg1", 0, 0, 0, 1, 0, 1);

    // two memory ops
    clr();
    v1 = 1; v2 = 1;
    mr1 = 1; rd1 = 4'd1;
    mw2 = 1; rn2 = 4'd3; urn2 = 1;
    run("mem0", 1, 1, 0, 0, 1, 0);
    run("mem1", 0, 0, 0, 1, 0, 1);

    // load-use on slot 2 Rm
    clr();
    v1 = 1; v2 = 1;
    mr1e = 1; rd1e = 4'd7;
    rd1 = 4'd1; rd2 = 4'd3;
    rm2 = 4'd7; urm2 = 1;
    run("lu0", 1, 1, 0, 1, 1, 0);
    mr1e = 0;
    run("lu1", 0, 0, 0, 0, 0, 0);

    // branch beats load-use
    mr1e = 1; br = 1;
    run("brlu", 0, 0, 1, 1, 1, 0);

    // branch while in SPLIT
    raw_pair();
    run("brs0", 1, 1, 0, 0, 1, 0);
    br = 1;
    run("brs1", 0, 0, 1, 1, 1, 1);
    br = 0;
    clr();
    run("brs2", 0, 0, 0, 0, 0, 0);

    // saturate the split counter
    raw_pair();
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      run("sat0", 1, 1, 0, 0, 1, 0);
      run("sat1", 0, 0, 0, 1, 0, 1);
    end
    clr();
    @(negedge clk);
    chk("satcnt", 8'(scnt), 8'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmps, fails);
    $finish;
  end

endmodule
